// File: rtl/odd_count_checker_pkg.sv
// Shared types and default parameters for the odd-sequence counter and its checker.
package odd_counter_pkg;

  localparam int unsigned DEF_WIDTH    = 8;
  localparam int unsigned DEF_LOCK_CNT = 4;
  localparam int unsigned DEF_LOSS_CNT = 3;
  localparam int unsigned DEF_ERR_W    = 16;
  localparam int unsigned STEP         = 2;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE  = 2'd0;
  localparam state_t ST_ACQ   = 2'd1;
  localparam state_t ST_TRACK = 2'd2;

endpackage

// File: rtl/odd_count_checker_if.sv
// Sample bus carrying the monitored counter value and its qualifier.
interface odd_count_checker_if #(
  parameter int unsigned WIDTH = odd_counter_pkg::DEF_WIDTH
) ();

  logic [WIDTH-1:0] count_in;
  logic             count_valid;

  modport master (output count_in, output count_valid);
  modport slave  (input  count_in, input  count_valid);

endinterface

// File: rtl/odd_count_checker_sat_counter.sv
// Saturating up-counter with synchronous reset and clear; clear wins over increment.
module sat_counter #(
  parameter int unsigned ERR_W = odd_counter_pkg::DEF_ERR_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  input  logic             clr,
  output logic [ERR_W-1:0] count
);

  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (inc && (count != '1)) begin
      count <= count + ERR_W'(1);
    end
  end

endmodule

// File: rtl/odd_count_checker.sv
// Monitors an odd-step counter: acquires lock on consecutive +2 steps, then
// flywheels its prediction and counts errors until a run of misses drops lock.
module odd_count_checker
  import odd_counter_pkg::*;
#(
  parameter int unsigned WIDTH    = DEF_WIDTH,
  parameter int unsigned LOCK_CNT = DEF_LOCK_CNT,
  parameter int unsigned LOSS_CNT = DEF_LOSS_CNT,
  parameter int unsigned ERR_W    = DEF_ERR_W
) (
  input  logic                      clk,
  input  logic                      rst,
  odd_count_checker_if.slave        bus,
  input  logic                      clr_err,
  output logic                      locked,
  output logic                      err_pulse,
  output logic [ERR_W-1:0]          err_count,
  output logic [WIDTH-1:0]          expected_out
);

  localparam int unsigned RUN_MAX = (LOCK_CNT > LOSS_CNT) ? LOCK_CNT : LOSS_CNT;
  localparam int unsigned RUN_W   = $clog2(RUN_MAX + 1);

  state_t           state, state_n;
  logic [WIDTH-1:0] prev, prev_n;
  logic [RUN_W-1:0] run, run_n, run_inc_c;
  logic [WIDTH-1:0] expected_c;
  logic             good_c;
  logic             pulse_n;
  logic             err_inc_c;
  logic [WIDTH-1:0] expected_out_n;

  assign expected_c = prev + WIDTH'(STEP);
  assign good_c     = bus.count_in[0] && (bus.count_in == expected_c);
  assign run_inc_c  = run + RUN_W'(1);

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= ST_IDLE;
      prev         <= '0;
      run          <= '0;
      err_pulse    <= 1'b0;
      locked       <= 1'b0;
      expected_out <= '0;
    end else begin
      state        <= state_n;
      prev         <= prev_n;
      run          <= run_n;
      err_pulse    <= pulse_n;
      locked       <= (state_n == ST_TRACK);
      expected_out <= expected_out_n;
    end
  end

  always_comb begin
    state_n   = state;
    prev_n    = prev;
    run_n     = run;
    pulse_n   = 1'b0;
    err_inc_c = 1'b0;
    if (bus.count_valid) begin
      case (state)
        ST_IDLE: begin
          if (bus.count_in[0]) begin
            state_n = ST_ACQ;
            prev_n  = bus.count_in;
            run_n   = '0;
          end
        end
        ST_ACQ: begin
          if (good_c) begin
            prev_n = bus.count_in;
            if (run_inc_c == RUN_W'(LOCK_CNT)) begin
              state_n = ST_TRACK;
              run_n   = '0;
            end else begin
              run_n = run_inc_c;
            end
          end else if (bus.count_in[0]) begin
            prev_n = bus.count_in;
            run_n  = '0;
          end else begin
            state_n = ST_IDLE;
            run_n   = '0;
          end
        end
        ST_TRACK: begin
          if (good_c) begin
            prev_n = bus.count_in;
            run_n  = '0;
          end else begin
            // Flywheel: advance the prediction and discard the bad value.
            pulse_n   = 1'b1;
            err_inc_c = 1'b1;
            prev_n    = expected_c;
            if (run_inc_c == RUN_W'(LOSS_CNT)) begin
              state_n = ST_IDLE;
              run_n   = '0;
            end else begin
              run_n = run_inc_c;
            end
          end
        end
        default: begin
          state_n = ST_IDLE;
          run_n   = '0;
        end
      endcase
    end
    expected_out_n = (state_n == ST_IDLE) ? '0 : (prev_n + WIDTH'(STEP));
  end

  sat_counter #(.ERR_W(ERR_W)) u_err_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (err_inc_c),
    .clr   (clr_err),
    .count (err_count)
  );

endmodule

// File: doc/odd_count_checker.md
# odd_count_checker

Downstream monitor for the odd-sequence counter: samples its `count` output and checks that every sample is odd and exactly 2 above the previous one (mod 2^WIDTH). It acquires lock on a run of good steps, then tracks with a flywheel prediction. It reports errors as a pulse plus a saturating counter, and drops lock after a run of consecutive bad samples.

## Interface
- `WIDTH`, 8: width of the checked count.
- `LOCK_CNT`, 4: consecutive good steps needed to lock (≥1).
- `LOSS_CNT`, 3: consecutive bad samples in TRACK that drop lock (≥1).
- `ERR_W`, 16: error counter width.

Ports:
- `clk`  in  1: single clock, all logic on the rising edge.
- `rst`  in  1: synchronous, active-high reset.
- `count_in`  in  WIDTH: counter value under check.
- `count_valid`  in  1: `count_in` is sampled on edges where this is high.
- `clr_err`  in  1: synchronous clear of `err_count`.
- `locked`  out  1: state is TRACK.
- `err_pulse`  out  1: one-cycle flag for a bad sample in TRACK.
- `err_count`  out  ERR_W: saturating count of TRACK errors.
- `expected_out`  out  WIDTH: predicted next value.

## Operation
- Registers:
  - `prev` (WIDTH)
  - `run` (good-step counter in ACQ, miss counter in TRACK)
  - state
  - `err_count`
  - `err_pulse`
- Definitions:
  - `expected = prev + 2`, truncated to WIDTH, so 255 + 2 → 1 at WIDTH=8.
  - A sample is **good** iff `count_in[0]` is 1 and `count_in == expected`.
- Edges with `count_valid` low: all state held, `err_pulse` driven 0.
- **IDLE**, with no reference:
  - Odd sample → ACQ, `prev` = sample, `run` = 0.
  - Even sample → stay in IDLE.
  - No error reporting.
- **ACQ**:
  - Good sample → `prev` = sample, `run`++. When `run` reaches `LOCK_CNT` → TRACK with `run` = 0.
  - Bad odd sample → restart ACQ: `prev` = sample, `run` = 0.
  - Bad even sample → IDLE.
  - No error reporting.
- **TRACK**:
  - Good sample → `prev` = sample, `run` = 0.
  - Bad sample:
    - `err_pulse` = 1 and `err_count` +1, saturating at all-ones.
    - `prev` = `expected` (flywheel; the bad value is discarded).
    - `run`++.
    - When `run` reaches `LOSS_CNT` → IDLE with `run` = 0.
- `clr_err` clears `err_count`:
  - It has priority over a simultaneous increment, so the result is 0.
  - `err_pulse` still asserts for that error.
- `expected_out` = `prev + 2` in ACQ/TRACK; 0 in IDLE.

## Timing
- All outputs are registered. A sample at edge k is reflected in the outputs right after edge k, with no further latency.
- `locked` rises on the edge that consumes the `LOCK_CNT`-th good step. It falls on the edge that consumes the `LOSS_CNT`-th consecutive bad sample.
- Reset mid-operation: on the next edge with `rst`=1:
  - State → IDLE.
  - `prev`, `run`, `err_count` → 0.
  - `err_pulse` → 0, `locked` → 0, `expected_out` → 0.
  - `rst` overrides `count_valid` and `clr_err`.
- Reset values: all outputs 0.
- Wrap-around is legal and is not an error. 2^WIDTH−1 → 1 is a good step.
- `err_count` at all-ones stays at all-ones; `err_pulse` still asserts.

## Structure
- Shared package `odd_counter_pkg`:
  - State typedef with IDLE, ACQ, TRACK.
  - Default localparams for WIDTH, LOCK_CNT, LOSS_CNT, ERR_W, and the step constant 2.
- One sub-module, `sat_counter`:
  - Parameter ERR_W.
  - Inputs `inc` and `clr` (clr priority), synchronous `rst`.
  - Instantiated for `err_count`.
- `run` is sized to hold max(LOCK_CNT, LOSS_CNT).

## Test plan
Defaults unless stated: WIDTH=8, LOCK_CNT=4, LOSS_CNT=3.
1. Lock: reset, then feed 1,3,5,7,9 with valid on every cycle → `locked` = 1 right after the edge sampling 9; `err_count` = 0; `expected_out` = 11.
2. Wrap: locked, feed 251,253,255,1,3 → no `err_pulse`; `locked` stays 1; `expected_out` = 5.
3. Glitch and flywheel: locked with `prev` = 11, feed 12 then 15 → one `err_pulse`, `err_count` = 1, `expected_out` = 15 after the glitch; 15 is accepted and `locked` stays 1.
4. Loss: locked with `prev` = 21, feed 40,40,40 → three `err_pulse`s, `err_count` = 3, `locked` = 0 after the third sample, `expected_out` = 0.
5. Valid gaps: in the lock sequence, drop `count_valid` for 5 cycles between samples with garbage on `count_in` → outputs unchanged during the gaps; lock timing in samples is the same as scenario 1.
6. Clear and reset: `clr_err` on the same edge as a TRACK error → `err_count` = 0 and `err_pulse` = 1. `rst` while locked with `err_count` = 2 → all outputs 0 next cycle; the first odd sample after reset enters ACQ.
